// File: rtl/agc_timepulse_ring.sv
// Timepulse ring for the AGC gate-level sim: divides clk into memory-cycle-time sequences
// of NTP one-hot timepulses with four phases each; supports free-run, single-step and GOJAM restart.
module agc_timepulse_ring #(
  parameter int unsigned NTP = 12,
  parameter int unsigned DIV = 2,
  parameter int unsigned CW  = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           run,
  input  logic           single,
  input  logic           step,
  input  logic           gojam,
  output logic [NTP-1:0] tp,
  output logic [1:0]     phase,
  output logic           mct_start,
  output logic           mct_end,
  output logic           busy,
  output logic [CW-1:0]  mct_count
);

  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [NTP-1:0]  tp_q, tp_d;
  logic [1:0]      phase_q, phase_d;
  logic [DW-1:0]   div_q, div_d;
  logic            start_q, start_d;
  logic            end_q, end_d;
  logic [CW-1:0]   count_q, count_d;
  logic            last_c;
  logic            div_wrap_c;
  logic            restart_c;
  logic            go_idle_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tp_q    <= '0;
      phase_q <= '0;
      div_q   <= '0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      tp_q    <= tp_d;
      phase_q <= phase_d;
      div_q   <= div_d;
      start_q <= start_d;
      end_q   <= end_d;
      count_q <= count_d;
    end
  end

  // Next-state: advance the divider/phase/ring, or restart at T01, or drop to idle.
  always_comb begin
    state_d    = state_q;
    tp_d       = tp_q;
    phase_d    = phase_q;
    div_d      = div_q;
    count_d    = count_q;
    restart_c  = 1'b0;
    go_idle_c  = 1'b0;
    div_wrap_c = (div_q == DW'(DIV - 1));
    last_c     = tp_q[NTP-1] && (phase_q == 2'd3) && div_wrap_c;

    case (state_q)
      IDLE: begin
        if ((!single && run) || (single && step)) restart_c = 1'b1;
      end
      RUN: begin
        if (last_c) begin
          count_d = count_q + CW'(1);
          if (gojam || (!single && run)) restart_c = 1'b1;
          else                           go_idle_c = 1'b1;
        end else if (gojam) begin
          restart_c = 1'b1;
        end else if (div_wrap_c) begin
          div_d   = '0;
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd3) tp_d = {tp_q[NTP-2:0], 1'b0};
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (restart_c) begin
      state_d = RUN;
      tp_d    = NTP'(1);
      phase_d = '0;
      div_d   = '0;
    end
    if (go_idle_c) begin
      state_d = IDLE;
      tp_d    = '0;
      phase_d = '0;
      div_d   = '0;
    end

    // Strobes are registered, so they are decoded from the state being loaded.
    start_d = restart_c;
    end_d   = (state_d == RUN) && tp_d[NTP-1] && (phase_d == 2'd3) && (div_d == DW'(DIV - 1));
  end

  assign tp        = tp_q;
  assign phase     = phase_q;
  assign mct_start = start_q;
  assign mct_end   = end_q;
  assign busy      = (state_q == RUN);
  assign mct_count = count_q;

endmodule

// File: tb/tb_agc_timepulse_ring.sv
// Bench for agc_timepulse_ring: stimulus pushes expected start/end strobes into a scoreboard,
// a negedge monitor pops and compares them, plus directed level checks along the way.
module tb_agc_timepulse_ring;

  localparam int unsigned NTP = 12;
  localparam int unsigned DIV = 2;
  localparam int unsigned CW  = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           run = 1'b0;
  logic           single = 1'b0;
  logic           step = 1'b0;
  logic           gojam = 1'b0;
  logic [NTP-1:0] tp;
  logic [1:0]     phase;
  logic           mct_start;
  logic           mct_end;
  logic           busy;
  logic [CW-1:0]  mct_count;

  typedef struct {
    int kind;
    int cyc;
    int cnt;
  } ev_t;

  ev_t sb[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  agc_timepulse_ring #(.NTP(NTP), .DIV(DIV), .CW(CW)) dut (
    .clk(clk), .rst(rst), .run(run), .single(single), .step(step), .gojam(gojam),
    .tp(tp), .phase(phase), .mct_start(mct_start), .mct_end(mct_end),
    .busy(busy), .mct_count(mct_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input int cnt);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.cnt  = cnt;
    sb.push_back(e);
  endtask

  task automatic wait_drv(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_neg(input int n);
    @(negedge clk);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic chk_idle(input string name, input int cnt);
    chk({name, "_tp"}, 32'(tp), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_count"}, 32'(mct_count), 32'(cnt));
  endtask

  // Monitor: pop the scoreboard on every strobe and check level invariants each cycle.
  always @(negedge clk) begin
    ev_t e;
    logic ok;
    ok = busy ? $onehot(tp) : (tp == '0);
    ok = ok && !(mct_start && mct_end);
    chk("invariant", 32'(ok), 32'd1);
    if (mct_start || mct_end) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", {30'd0, mct_end, mct_start}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk(mct_end ? "strobe_end" : "strobe_start",
            {8'(mct_end), 16'(cyc), 8'(mct_count)},
            {8'(e.kind), 16'(e.cyc), 8'(e.cnt)});
      end
    end
  end

  initial begin
    int s, s2, s3, s5, s6, s7, s8, r;

    // Reset held, then released with run low: stays idle.
    repeat (3) @(posedge clk);
    #1;
    chk_idle("in_reset", 0);
    chk("in_reset_start", 32'(mct_start), 32'd0);
    rst = 1'b1;
    r = cyc;
    for (int i = 1; i <= 20; i++) begin
      wait_neg(r + i);
      chk_idle("post_reset", 0);
    end

    // Free-run MCT timing.
    wait_drv(r + 21);
    run = 1'b1;
    s = cyc + 1;
    push(0, s, 0);
    push(1, s + 95, 0);
    push(0, s + 96, 1);
    wait_neg(s);
    chk("t01_first", 32'(tp), 32'h001);
    chk("t01_phase", 32'(phase), 32'd0);
    chk("t01_busy", 32'(busy), 32'd1);
    wait_neg(s + 7);
    chk("t01_last", 32'(tp), 32'h001);
    chk("t01_last_phase", 32'(phase), 32'd3);
    wait_neg(s + 8);
    chk("t02_first", 32'(tp), 32'h002);
    chk("t02_phase", 32'(phase), 32'd0);
    wait_neg(s + 88);
    chk("t12_first", 32'(tp), 32'h800);
    wait_neg(s + 95);
    chk("t12_last", 32'(tp), 32'h800);
    chk("t12_last_phase", 32'(phase), 32'd3);
    wait_neg(s + 96);
    chk("mct2_tp", 32'(tp), 32'h001);
    chk("mct2_count", 32'(mct_count), 32'd1);

    // GOJAM during T05 phase 2 restarts without completing the MCT.
    s2 = s + 96;
    wait_drv(s2 + 36);
    chk("pre_gojam_tp", 32'(tp), 32'h010);
    chk("pre_gojam_phase", 32'(phase), 32'd2);
    gojam = 1'b1;
    push(0, s2 + 37, 1);
    wait_drv(s2 + 37);
    gojam = 1'b0;
    wait_neg(s2 + 37);
    chk("gojam_tp", 32'(tp), 32'h001);
    chk("gojam_phase", 32'(phase), 32'd0);
    chk("gojam_count", 32'(mct_count), 32'd1);
    s3 = s2 + 37;

    // run dropped in T03: MCT completes, then idle.
    wait_drv(s3 + 18);
    run = 1'b0;
    push(1, s3 + 95, 1);
    wait_neg(s3 + 94);
    chk("rundrop_busy", 32'(busy), 32'd1);
    wait_neg(s3 + 96);
    chk_idle("rundrop_idle", 2);
    wait_neg(s3 + 100);
    chk_idle("rundrop_hold", 2);

    // Single-step: one MCT per step, steps during an MCT ignored.
    wait_drv(s3 + 101);
    single = 1'b1;
    step = 1'b1;
    s5 = cyc + 1;
    push(0, s5, 2);
    push(1, s5 + 95, 2);
    wait_drv(s5);
    step = 1'b0;
    wait_drv(s5 + 40);
    step = 1'b1;
    wait_drv(s5 + 41);
    step = 1'b0;
    wait_neg(s5 + 96);
    chk_idle("step1_idle", 3);
    wait_neg(s5 + 99);
    chk_idle("step1_hold", 3);
    wait_drv(s5 + 100);
    step = 1'b1;
    s6 = cyc + 1;
    push(0, s6, 3);
    push(1, s6 + 95, 3);
    wait_drv(s6);
    step = 1'b0;
    wait_neg(s6 + 96);
    chk_idle("step2_wrap_idle", 0);

    // Free run for five MCTs with a 2-bit counter, then async reset mid-T07.
    wait_drv(s6 + 98);
    single = 1'b0;
    run = 1'b1;
    s7 = cyc + 1;
    for (int k = 0; k < 5; k++) begin
      push(0, s7 + 96 * k, k % 4);
      push(1, s7 + 96 * k + 95, k % 4);
    end
    s8 = s7 + 480;
    push(0, s8, 1);
    for (int k = 0; k < 5; k++) begin
      wait_neg(s7 + 96 * (k + 1));
      chk("wrap_count", 32'(mct_count), 32'((k + 1) % 4));
    end
    wait_drv(s8 + 50);
    chk("pre_rst_tp", 32'(tp), 32'h040);
    rst = 1'b0;
    #1;
    chk_idle("async_rst", 0);
    chk("async_rst_phase", 32'(phase), 32'd0);
    chk("async_rst_strobes", {30'd0, mct_start, mct_end}, 32'd0);
    run = 1'b0;
    wait_drv(s8 + 53);
    rst = 1'b1;
    wait_neg(s8 + 60);
    chk_idle("after_rst", 0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
